descramble_sync: RTL and testbench

Receive-side descrambler controller for the 100BASE-TX PCS. It acquires the 11-bit descrambler LFSR state (x^11 + x^9 + 1) from the received idle stream and verifies the acquisition. It then free-runs the LFSR to descramble data and drops lock when idles stop confirming synchronisation. It sits between the NRZI/MLT-3 decoded bit stream and the 4B/5B alignment logic.

---
 rtl/descramble_sync_pkg.sv | 22 ++
 rtl/descramble_sync_lfsr11.sv | 32 +++
 rtl/descramble_sync.sv | 179 +++++++++++++++++
 tb/tb_descramble_sync.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/descramble_sync_pkg.sv
// rtl/descramble_sync_pkg.sv - shared LFSR constants and state encoding for the descrambler
package descramble_sync_pkg;

  // x^11 + x^9 + 1: width and feedback taps, shared with the transmit scrambler
  localparam int LFSR_W     = 11;
  localparam int LFSR_TAP_A = 8;
  localparam int LFSR_TAP_B = 10;

  // seed counter value on the edge consuming the last seed bit
  localparam logic [3:0] SEED_LAST = 4'(LFSR_W - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_VERIFY   = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/descramble_sync_lfsr11.sv
// rtl/descramble_sync_lfsr11.sv - 11-bit LFSR with serial seed load and free-run step
module descramble_sync_lfsr11
  import descramble_sync_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_step,
  input  logic              i_load,
  input  logic              i_load_bit,
  output logic [LFSR_W-1:0] o_state,
  output logic              o_next
);

  logic [LFSR_W-1:0] r_state;
  logic              w_next;

  assign w_next  = r_state[LFSR_TAP_A] ^ r_state[LFSR_TAP_B];
  assign o_state = r_state;
  assign o_next  = w_next;

  // seeding shifts in the external bit; stepping shifts in the feedback bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
    end else if (i_load) begin
      r_state <= {r_state[LFSR_W-2:0], i_load_bit};
    end else if (i_step) begin
      r_state <= {r_state[LFSR_W-2:0], w_next};
    end
  end

endmodule

// File: rtl/descramble_sync.sv
// rtl/descramble_sync.sv - 100BASE-TX receive descrambler with idle-based lock acquisition
module descramble_sync
  import descramble_sync_pkg::*;
#(
  parameter int LOCK_BITS   = 29,
  parameter int IDLE_RUN    = 29,
  parameter int HOLD_CYCLES = 90250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scrambled,
  input  logic scrambled_valid,
  input  logic force_unlock,
  output logic descrambled,
  output logic descrambled_valid,
  output logic locked
);

  localparam int RUN_W  = $clog2(max_int(LOCK_BITS, IDLE_RUN) + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [RUN_W-1:0]  RUN_LOCK   = RUN_W'(LOCK_BITS);
  localparam logic [RUN_W-1:0]  RUN_IDLE   = RUN_W'(IDLE_RUN);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_seed_cnt;
  logic [3:0]        w_seed_nxt;
  logic [RUN_W-1:0]  r_run_cnt;
  logic [RUN_W-1:0]  w_run_nxt;
  logic [RUN_W-1:0]  w_run_inc;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_desc;
  logic              w_desc_nxt;
  logic              r_desc_valid;
  logic              w_desc_valid_nxt;

  logic              w_lfsr_step;
  logic              w_lfsr_load;
  logic              w_lfsr_next;
  logic [LFSR_W-1:0] w_lfsr_state;
  logic              w_unused_state;
  logic              w_desc_bit;
  logic              w_reload;

  descramble_sync_lfsr11 u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_step     (w_lfsr_step),
    .i_load     (w_lfsr_load),
    .i_load_bit (~scrambled),
    .o_state    (w_lfsr_state),
    .o_next     (w_lfsr_next)
  );

  // the full state is only needed by the transmit side
  assign w_unused_state = ^w_lfsr_state;

  // an idle bit (1) descrambles to 1 when the LFSR is in step with the sender
  assign w_desc_bit = scrambled ^ w_lfsr_next;

  // run counter saturates rather than wrapping
  assign w_run_inc = (r_run_cnt == '1) ? r_run_cnt : r_run_cnt + RUN_W'(1);

  assign descrambled       = r_desc;
  assign descrambled_valid = r_desc_valid;
  assign locked            = (r_state == ST_LOCKED);

  // next-state, counters and output capture; force_unlock beats reload beats expiry
  always_comb begin
    w_state_nxt      = r_state;
    w_seed_nxt       = r_seed_cnt;
    w_run_nxt        = r_run_cnt;
    w_hold_nxt       = (r_hold_cnt != '0) ? r_hold_cnt - HOLD_W'(1) : '0;
    w_desc_nxt       = r_desc;
    w_desc_valid_nxt = 1'b0;
    w_lfsr_step      = 1'b0;
    w_lfsr_load      = 1'b0;
    w_reload         = 1'b0;

    if (force_unlock) begin
      w_state_nxt = ST_UNLOCKED;
      w_seed_nxt  = '0;
      w_run_nxt   = '0;
      w_hold_nxt  = '0;
      w_desc_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_UNLOCKED: begin
          if (scrambled_valid) begin
            w_lfsr_load = 1'b1;
            w_seed_nxt  = r_seed_cnt + 4'd1;
            if (r_seed_cnt == SEED_LAST) begin
              w_state_nxt = ST_VERIFY;
              w_seed_nxt  = '0;
              w_run_nxt   = '0;
            end
          end
        end

        ST_VERIFY: begin
          if (scrambled_valid) begin
            w_lfsr_step = 1'b1;
            if (w_desc_bit) begin
              w_run_nxt = w_run_inc;
              if (w_run_inc == RUN_LOCK) begin
                w_state_nxt = ST_LOCKED;
                w_hold_nxt  = HOLD_LOAD;
                w_run_nxt   = '0;
              end
            end else begin
              // mismatch: the offending bit is not reused as a seed bit
              w_state_nxt = ST_UNLOCKED;
              w_seed_nxt  = '0;
              w_run_nxt   = '0;
            end
          end
        end

        ST_LOCKED: begin
          if (scrambled_valid) begin
            w_lfsr_step      = 1'b1;
            w_desc_nxt       = w_desc_bit;
            w_desc_valid_nxt = 1'b1;
            if (w_desc_bit) begin
              if (w_run_inc == RUN_IDLE) begin
                w_reload   = 1'b1;
                w_hold_nxt = HOLD_LOAD;
                w_run_nxt  = '0;
              end else begin
                w_run_nxt = w_run_inc;
              end
            end else begin
              w_run_nxt = '0;
            end
          end
          // expiry: a bit consumed on this edge is dropped
          if (!w_reload && (r_hold_cnt == HOLD_LAST)) begin
            w_state_nxt      = ST_UNLOCKED;
            w_desc_nxt       = 1'b0;
            w_desc_valid_nxt = 1'b0;
            w_run_nxt        = '0;
          end
        end

        default: begin
          w_state_nxt = ST_UNLOCKED;
          w_seed_nxt  = '0;
          w_run_nxt   = '0;
          w_hold_nxt  = '0;
          w_desc_nxt  = 1'b0;
        end
      endcase
    end
  end

  // state, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_UNLOCKED;
      r_seed_cnt   <= '0;
      r_run_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_desc       <= 1'b0;
      r_desc_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_seed_cnt   <= w_seed_nxt;
      r_run_cnt    <= w_run_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_desc       <= w_desc_nxt;
      r_desc_valid <= w_desc_valid_nxt;
    end
  end

endmodule

// File: tb/tb_descramble_sync.sv
// tb/tb_descramble_sync.sv - scoreboard bench for descramble_sync against a bit-history model
module tb_descramble_sync;

  localparam int LOCK_BITS = 29;
  localparam int IDLE_RUN  = 29;
  localparam int HOLD      = 200;

  logic clk;
  logic rst_n;
  logic scrambled;
  logic scrambled_valid;
  logic force_unlock;
  logic descrambled;
  logic descrambled_valid;
  logic locked;

  descramble_sync #(
    .LOCK_BITS   (LOCK_BITS),
    .IDLE_RUN    (IDLE_RUN),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .scrambled         (scrambled),
    .scrambled_valid   (scrambled_valid),
    .force_unlock      (force_unlock),
    .descrambled       (descrambled),
    .descrambled_valid (descrambled_valid),
    .locked            (locked)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    bit lk;
    bit dv;
    bit d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   outputs_seen = 0;

  // transmit keystream history (seeded all ones) and receiver model
  bit tx_key[$];
  bit m_key[$];
  int m_st;     // 0 seeking seed, 1 verifying, 2 locked
  int m_seed;
  int m_run;
  int m_hold;
  bit m_dout;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_seed = 0; m_run = 0; m_hold = 0; m_dout = 0;
    m_key.delete();
    repeat (11) m_key.push_back(1'b0);
  endtask

  // receiver behaviour: after 11 seed bits the key is predicted from history
  task automatic model_step(input bit v, input bit s, input bit f, output exp_t e);
    int st0, hold0;
    bit reload, dv, pred, d;
    dv = 0;
    if (f) begin
      m_st = 0; m_seed = 0; m_run = 0; m_hold = 0; m_dout = 0;
    end else begin
      st0 = m_st; hold0 = m_hold; reload = 0;
      if (m_hold > 0) m_hold--;
      if (v) begin
        if (st0 == 0) begin
          m_key.push_back(!s);
          m_seed++;
          if (m_seed == 11) begin m_st = 1; m_seed = 0; m_run = 0; end
        end else begin
          pred = m_key[$-8] ^ m_key[$-10];
          m_key.push_back(pred);
          d = s ^ pred;
          if (st0 == 1) begin
            if (d) begin
              m_run++;
              if (m_run == LOCK_BITS) begin m_st = 2; m_hold = HOLD; m_run = 0; end
            end else begin
              m_st = 0; m_seed = 0; m_run = 0;
            end
          end else begin
            dv = 1; m_dout = d;
            if (d) begin
              m_run++;
              if (m_run == IDLE_RUN) begin reload = 1; m_hold = HOLD; m_run = 0; end
            end else m_run = 0;
          end
        end
        if (m_key.size() > 64) m_key.delete(0);
      end
      if (st0 == 2 && !reload && hold0 == 1) begin
        m_st = 0; dv = 0; m_dout = 0; m_run = 0;
      end
    end
    e.lk = (m_st == 2);
    e.dv = dv;
    e.d  = m_dout;
  endtask

  // one clock of stimulus; flip corrupts the line bit
  task automatic tick(input bit v, input bit data, input bit f, input bit flip);
    bit k, s;
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    if (v) begin
      k = tx_key[$-8] ^ tx_key[$-10];
      tx_key.push_back(k);
      if (tx_key.size() > 32) tx_key.delete(0);
      s = data ^ k ^ flip;
    end else begin
      s = 1'($urandom);
    end
    scrambled = s; scrambled_valid = v; force_unlock = f;
    model_step(v, s, f, e);
    exp_q.push_back(e);
  endtask

  task automatic async_reset(input string name);
    exp_t e;
    @(negedge clk);
    scrambled_valid = 1'b0; force_unlock = 1'b0;
    model_reset();
    e.lk = 0; e.dv = 0; e.d = 0;
    exp_q.push_back(e);
    #2 rst_n = 1'b0;
    #1;
    chk({name, "_locked"}, locked, 0);
    chk({name, "_dvalid"}, descrambled_valid, 0);
    chk({name, "_desc"}, descrambled, 0);
    @(posedge clk);
  endtask

  task automatic probe(input string name, input bit exp);
    @(posedge clk); #1;
    chk(name, locked, exp);
  endtask

  // monitor: one expected record per clock, data compared when valid
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("locked", locked, e.lk);
        chk("descrambled_valid", descrambled_valid, e.dv);
        if (e.dv) begin
          outputs_seen++;
          chk("descrambled", descrambled, e.d);
        end
      end
    end
  end

  initial begin
    int mode;
    rst_n = 1'b0; scrambled = 1'b0; scrambled_valid = 1'b0; force_unlock = 1'b0;
    repeat (11) tx_key.push_back(1'b1);
    model_reset();

    // clean acquisition
    async_reset("reset");
    for (int i = 1; i <= 60; i++) begin
      tick(1, 1, 0, 0);
      if (i == 39) probe("t1_not_yet", 0);
      if (i == 40) probe("t1_lock_at_40", 1);
    end

    // error during verify at bit 20
    async_reset("reset_t2");
    for (int i = 1; i <= 80; i++) begin
      tick(1, 1, 0, i == 20);
      if (i == 40) probe("t2_no_lock_40", 0);
      if (i == 59) probe("t2_not_yet", 0);
      if (i == 60) probe("t2_lock_at_60", 1);
    end

    // hold timer expiry with no idle runs
    async_reset("reset_t3a");
    repeat (40) tick(1, 1, 0, 0);
    for (int k = 1; k <= 220; k++) begin
      tick(1, k % 2 == 0, 0, 0);
      if (k == 199) probe("t3a_held_199", 1);
      if (k == 200) probe("t3a_drop_200", 0);
    end

    // idle run ending at 150 extends lock to 350
    async_reset("reset_t3b");
    repeat (40) tick(1, 1, 0, 0);
    for (int k = 1; k <= 370; k++) begin
      tick(1, (k >= 122 && k <= 150) ? 1'b1 : (k % 2 == 0), 0, 0);
      if (k == 200) probe("t3b_held_200", 1);
      if (k == 349) probe("t3b_held_349", 1);
      if (k == 350) probe("t3b_drop_350", 0);
    end

    // reload coincides with expiry at 200
    async_reset("reset_t4");
    repeat (40) tick(1, 1, 0, 0);
    for (int k = 1; k <= 420; k++) begin
      tick(1, (k >= 172 && k <= 200) ? 1'b1 : (k % 2 == 0), 0, 0);
      if (k == 200) probe("t4_held_200", 1);
      if (k == 201) probe("t4_held_201", 1);
      if (k == 399) probe("t4_held_399", 1);
      if (k == 400) probe("t4_drop_400", 0);
    end

    // force_unlock while locked with a valid bit
    async_reset("reset_t5");
    repeat (50) tick(1, 1, 0, 0);
    tick(1, 1, 1, 0);
    @(posedge clk); #1;
    chk("t5_force_locked", locked, 0);
    chk("t5_force_dvalid", descrambled_valid, 0);
    for (int i = 1; i <= 45; i++) begin
      tick(1, 1, 0, 0);
      if (i == 39) probe("t5_relock_not_yet", 0);
      if (i == 40) probe("t5_relock_40", 1);
    end

    // asynchronous reset mid-lock and mid-verify
    repeat (10) tick(1, 1, 0, 0);
    async_reset("t5_rst_locked");
    repeat (20) tick(1, 1, 0, 0);
    async_reset("t5_rst_verify");

    // sparse valid: one bit every third clock
    for (int i = 1; i <= 40; i++) begin
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      tick(1, 1, 0, 0);
      if (i == 40) probe("t6_lock_sparse", 1);
    end
    for (int k = 1; k <= 210; k++) begin
      tick(k % 3 == 0, k % 6 == 0, 0, 0);
      if (k == 199) probe("t6_held_199", 1);
      if (k == 200) probe("t6_drop_200", 0);
    end

    // randomized traffic: idle, alternating and random stretches
    async_reset("reset_rand");
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      bit v, dat, f;
      if (c % 128 == 0) mode = $urandom_range(0, 3);
      v = ($urandom_range(0, 3) != 0);
      case (mode)
        0, 1:    dat = 1'b1;
        2:       dat = c[0];
        default: dat = 1'($urandom);
      endcase
      f = ($urandom_range(0, 699) == 0);
      tick(v, dat, f, $urandom_range(0, 299) == 0);
    end

    @(posedge clk); #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("outputs_observed", outputs_seen > 100, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
